mt19937_gen: RTL and testbench

Hardware MT19937 pseudo-random number generator, bit-exact with the standard 32-bit Mersenne Twister (the C++ `std::mt19937` definition). It produces one tempered 32-bit word per clock once initialised. It is a self-contained stimulus source for stochastic blocks, and it is re-seedable at run time through a single-cycle strobe.

---
 rtl/mt19937_pkg.sv | 39 +++
 rtl/mt19937_temper.sv | 18 +
 rtl/mt19937_gen.sv | 101 ++++++++++
 tb/tb_mt19937_gen.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/mt19937_pkg.sv
// Algorithm constants, index helper and FSM state type for the MT19937 generator.
// Values match the standard 32-bit Mersenne Twister (std::mt19937).
package mt19937_pkg;

  localparam int unsigned N = 624;
  localparam int unsigned M = 397;

  localparam logic [9:0] IDX_LAST = 10'(N - 1);
  localparam logic [9:0] IDX_M    = 10'(M);

  localparam logic [31:0] MATRIX_A   = 32'h9908_B0DF;
  localparam logic [31:0] UPPER_MASK = 32'h8000_0000;
  localparam logic [31:0] LOWER_MASK = 32'h7FFF_FFFF;
  localparam logic [31:0] INIT_MULT  = 32'd1812433253;

  localparam int unsigned TEMPER_U = 11;
  localparam int unsigned TEMPER_S = 7;
  localparam int unsigned TEMPER_T = 15;
  localparam int unsigned TEMPER_L = 18;

  localparam logic [31:0] TEMPER_B = 32'h9D2C_5680;
  localparam logic [31:0] TEMPER_C = 32'hEFC6_0000;

  typedef enum logic {
    StSeed,
    StGen
  } state_e;

  // (a + b) mod N for a, b already in 0..N-1.
  function automatic logic [9:0] idx_add(input logic [9:0] a, input logic [9:0] b);
    logic [10:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum >= 11'(N)) begin
      sum = sum - 11'(N);
    end
    return sum[9:0];
  endfunction

endpackage

// File: rtl/mt19937_temper.sv
// MT19937 output tempering: purely combinational 32-bit bijection.
module mt19937_temper
  import mt19937_pkg::*;
(
  input  logic [31:0] i_x,
  output logic [31:0] o_y
);

  logic [31:0] w_t1;
  logic [31:0] w_t2;
  logic [31:0] w_t3;

  assign w_t1 = i_x  ^ (i_x >> TEMPER_U);
  assign w_t2 = w_t1 ^ ((w_t1 << TEMPER_S) & TEMPER_B);
  assign w_t3 = w_t2 ^ ((w_t2 << TEMPER_T) & TEMPER_C);
  assign o_y  = w_t3 ^ (w_t3 >> TEMPER_L);

endmodule

// File: rtl/mt19937_gen.sv
// MT19937 generator: 624-cycle seeding pass, then one tempered word per clock using an
// in-place twist, so wrapped reads naturally see already-rewritten words.
module mt19937_gen
  import mt19937_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] seed,
  input  logic        re_seed,
  output logic [31:0] rnd,
  output logic        valid
);

  state_e      r_state;
  state_e      w_state_next;
  logic [9:0]  r_idx;
  logic [9:0]  w_idx_next;
  logic [31:0] r_mt [N];
  logic [31:0] r_rnd;
  logic        r_valid;

  logic        w_restart;
  logic [9:0]  w_idx_p1;
  logic [9:0]  w_idx_pm;
  logic [31:0] w_prev;
  logic [31:0] w_seed_word;
  logic [31:0] w_y;
  logic [31:0] w_x;
  logic [31:0] w_tempered;

  // Reset and re_seed share one restart path; reset simply wins by also being a restart.
  assign w_restart = ~rst_n | re_seed;

  assign w_idx_p1 = idx_add(r_idx, 10'd1);
  assign w_idx_pm = idx_add(r_idx, IDX_M);

  // Seeding recurrence, only meaningful while r_idx is 1..623.
  assign w_prev      = r_mt[r_idx - 10'd1];
  assign w_seed_word = INIT_MULT * (w_prev ^ (w_prev >> 30)) + {22'd0, r_idx};

  // Twist for the word at r_idx.
  assign w_y = (r_mt[r_idx] & UPPER_MASK) | (r_mt[w_idx_p1] & LOWER_MASK);
  assign w_x = r_mt[w_idx_pm] ^ (w_y >> 1) ^ (w_y[0] ? MATRIX_A : 32'd0);

  mt19937_temper u_temper (
    .i_x (w_x),
    .o_y (w_tempered)
  );

  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    unique case (r_state)
      StSeed: begin
        if (r_idx == IDX_LAST) begin
          w_state_next = StGen;
          w_idx_next   = 10'd0;
        end else begin
          w_idx_next = r_idx + 10'd1;
        end
      end
      StGen: begin
        w_idx_next = w_idx_p1;
      end
      default: begin
        w_state_next = StSeed;
      end
    endcase
    if (w_restart) begin
      w_state_next = StSeed;
      w_idx_next   = 10'd1;
    end
  end

  always_ff @(posedge clk) begin
    r_state <= w_state_next;
    r_idx   <= w_idx_next;
  end

  always_ff @(posedge clk) begin
    if (w_restart) begin
      r_mt[0] <= seed;
      r_rnd   <= 32'd0;
      r_valid <= 1'b0;
    end else if (r_state == StSeed) begin
      r_mt[r_idx] <= w_seed_word;
    end else begin
      r_mt[r_idx] <= w_x;
      r_rnd       <= w_tempered;
      r_valid     <= 1'b1;
    end
  end

  assign rnd   = r_rnd;
  assign valid = r_valid;

  a_idx_range : assert property (@(posedge clk) disable iff (!rst_n) r_idx <= IDX_LAST);
  a_seed_quiet : assert property (@(posedge clk) disable iff (!rst_n)
                                  (r_state == StSeed) |-> (r_idx != 10'd0));

endmodule

// File: tb/tb_mt19937_gen.sv
// Scoreboard bench for mt19937_gen against a batch-twist software Mersenne Twister model.
module tb_mt19937_gen;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re_seed;
  logic [31:0] seed;
  logic [31:0] rnd;
  logic        valid;

  mt19937_gen dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .seed    (seed),
    .re_seed (re_seed),
    .rnd     (rnd),
    .valid   (valid)
  );

  initial forever #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [31:0] got_q[$];

  // Reference model: classic generator that twists all 624 words at once.
  logic [31:0] m_mt [624];
  int          m_idx;

  function automatic void model_seed(input logic [31:0] s);
    m_mt[0] = s;
    for (int k = 1; k < 624; k++) begin
      m_mt[k] = 32'd1812433253 * (m_mt[k-1] ^ (m_mt[k-1] >> 30)) + 32'(k);
    end
    m_idx = 624;
  endfunction

  function automatic logic [31:0] model_next();
    logic [31:0] y;
    if (m_idx >= 624) begin
      for (int j = 0; j < 624; j++) begin
        y = (m_mt[j] & 32'h8000_0000) | (m_mt[(j + 1) % 624] & 32'h7FFF_FFFF);
        m_mt[j] = m_mt[(j + 397) % 624] ^ (y >> 1) ^ (y[0] ? 32'h9908_B0DF : 32'h0);
      end
      m_idx = 0;
    end
    y = m_mt[m_idx];
    m_idx++;
    y = y ^ (y >> 11);
    y = y ^ ((y << 7) & 32'h9D2C_5680);
    y = y ^ ((y << 15) & 32'hEFC6_0000);
    y = y ^ (y >> 18);
    return y;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%08h), expected %0d (0x%08h)", name, act, act, req, req);
    end
  endtask

  // Monitor: every valid word consumes one expectation while any are outstanding.
  always @(negedge clk) begin : monitor
    logic [31:0] e;
    if (valid === 1'b1 && exp_q.size() != 0) begin
      e = exp_q.pop_front();
      got_q.push_back(rnd);
      check($sformatf("word %0d", got_q.size()), rnd, e);
    end
  end

  // Hold the restart request for 'hold' edges; only the last edge uses last_seed.
  task automatic restart(input int hold, input logic [31:0] last_seed, input bit use_rst,
                         input bit use_re);
    for (int h = 0; h < hold; h++) begin
      seed    = (h == hold - 1) ? last_seed : $urandom;
      rst_n   = ~use_rst;
      re_seed = use_re;
      @(posedge clk);
      #1;
    end
    rst_n   = 1'b1;
    re_seed = 1'b0;
    seed    = $urandom;
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic push_expected(input int n, input logic [31:0] s);
    model_seed(s);
    for (int i = 0; i < n; i++) exp_q.push_back(model_next());
  endtask

  // Called right after the sampling edge: valid must first be seen 624 edges later.
  task automatic check_gap(input string name);
    int first = -1;
    int bad   = 0;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        first = c;
        break;
      end
      if (rnd !== 32'd0) bad++;
    end
    check({name, " first valid cycle"}, 32'(first), 32'd624);
    check({name, " rnd nonzero while idle"}, 32'(bad), 32'd0);
  endtask

  // Wait for the scoreboard to empty while wiggling seed without a restart.
  task automatic drain(input string name, input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(negedge clk);
      seed = $urandom;
      n++;
    end
    check({name, " words outstanding"}, 32'(exp_q.size()), 32'd0);
    exp_q.delete();
  endtask

  initial begin : timeout
    #2_000_000;
    $display("FAIL timeout: simulation did not complete, %0d of %0d checks failed",
             n_fail, n_tests);
    $fatal(1, "timeout");
  end

  initial begin : stimulus
    logic [31:0] kat [5];
    logic [31:0] s;
    kat[0] = 32'd3499211612;
    kat[1] = 32'd581869302;
    kat[2] = 32'd3890346734;
    kat[3] = 32'd3586334585;
    kat[4] = 32'd545404204;

    rst_n   = 1'b0;
    re_seed = 1'b0;
    seed    = 32'd5489;

    // Power-on reset, long run with seed port toggling throughout.
    restart(1, 32'd5489, 1'b1, 1'b0);
    push_expected(10000, 32'd5489);
    check_gap("reset");
    drain("run 5489", 10200);
    check("kat count", 32'(got_q.size()), 32'd10000);
    if (got_q.size() >= 10000) begin
      for (int i = 0; i < 5; i++) check($sformatf("kat %0d", i + 1), got_q[i], kat[i]);
      check("kat 10000", got_q[9999], 32'd4123659995);
    end

    // Reseed while generating.
    repeat (17) @(posedge clk);
    #1;
    restart(1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    push_expected(1000, 32'hDEAD_BEEF);
    check_gap("reseed gen");
    drain("deadbeef", 1100);

    // Abort seeding at cycle 300.
    restart(1, 32'd5489, 1'b0, 1'b1);
    repeat (299) @(posedge clk);
    #1;
    restart(1, 32'hCAFE_BABE, 1'b0, 1'b1);
    push_expected(1000, 32'hCAFE_BABE);
    check_gap("reseed seed");
    drain("cafebabe", 1100);

    // Reset and re_seed on the same edge.
    s = $urandom;
    restart(1, s, 1'b1, 1'b1);
    push_expected(700, s);
    check_gap("rst+reseed");
    drain("rst+reseed", 800);

    // re_seed held for five edges with a different seed on each.
    s = $urandom;
    restart(5, s, 1'b0, 1'b1);
    push_expected(700, s);
    check_gap("hold5");
    drain("hold5", 800);

    // Random seeds, random restart times.
    for (int r = 0; r < 3; r++) begin
      repeat ($urandom_range(0, 40)) @(posedge clk);
      #1;
      s = $urandom;
      restart(1, s, 1'b0, 1'b1);
      push_expected(int'($urandom_range(50, 300)), s);
      check_gap($sformatf("random %0d", r));
      drain($sformatf("random %0d", r), 400);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
